// File: rtl/adder_bist_pkg.sv
// Shared types and constants for the adder BIST controller.
// Holds the FSM state encoding, the LFSR tap mask and seed helpers.
package adder_bist_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Taps for x^8+x^6+x^5+x^4+1 in shift-left Fibonacci form: bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS     = 8'hB8;
  localparam logic [7:0] SEED_ZERO_SUB = 8'h01;
  localparam logic [7:0] NO_FAIL       = 8'hFF;
  localparam logic [7:0] ERR_MAX       = 8'hFF;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

  // An all-zero seed would lock the LFSR, so it is swapped for a legal one.
  function automatic logic [7:0] seed_fix(input logic [7:0] seed);
    return (seed == 8'h00) ? SEED_ZERO_SUB : seed;
  endfunction

endpackage

// File: rtl/adder_bist_if.sv
// Bus between the BIST controller (master) and the adder under test plus
// whoever launches runs (slave side).
interface adder_bist_if;
  logic       start;
  logic [7:0] num_vec;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] sum_in;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_cnt;
  logic [7:0] first_fail;

  modport master (
    input  start, num_vec, sum_in,
    output op_a, op_b, busy, done, pass, err_cnt, first_fail
  );

  modport slave (
    output start, num_vec, sum_in,
    input  op_a, op_b, busy, done, pass, err_cnt, first_fail
  );
endinterface

// File: rtl/adder_bist_lfsr8.sv
// 8-bit Fibonacci LFSR with synchronous load and step enables.
// Load has priority over step; reset clears the register to zero.
module lfsr8
  import adder_bist_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       load_i,
  input  logic       step_i,
  input  logic [7:0] seed_i,
  output logic [7:0] value_o
);

  logic [7:0] value_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value_q <= '0;
    end else if (load_i) begin
      value_q <= seed_i;
    end else if (step_i) begin
      value_q <= lfsr_next(value_q);
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/adder_bist.sv
// BIST controller for an 8-bit adder: drives LFSR operand pairs, checks the
// returned sum, and reports error count, first failing index and pass/fail.
module adder_bist
  import adder_bist_pkg::*;
#(
  parameter logic [7:0] SEED_A = 8'hA5,
  parameter logic [7:0] SEED_B = 8'h3C
) (
  input  logic         clk,
  input  logic         rst,
  adder_bist_if.master bus
);

  localparam logic [1:0][7:0] SEEDS = {seed_fix(SEED_B), seed_fix(SEED_A)};

  state_e     state_q;
  logic [7:0] vec_cnt_q;
  logic [7:0] err_cnt_q;
  logic [7:0] err_cnt_d;
  logic [7:0] first_fail_q;
  logic [7:0] first_fail_d;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;

  logic       lfsr_load;
  logic       lfsr_step;
  logic [7:0] lfsr_val [2];
  logic [7:0] exp_sum;
  logic [7:0] last_idx;
  logic       mismatch;
  logic       last_vec;

  assign lfsr_load = (state_q == ST_IDLE) && bus.start;
  assign lfsr_step = (state_q == ST_CHECK) && !last_vec;

  for (genvar gi = 0; gi < 2; gi++) begin : g_lfsr
    lfsr8 u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load_i  (lfsr_load),
      .step_i  (lfsr_step),
      .seed_i  (SEEDS[gi]),
      .value_o (lfsr_val[gi])
    );
  end

  // 8-bit sum drops the carry; num_vec of 0 wraps to a last index of 255.
  assign exp_sum  = lfsr_val[0] + lfsr_val[1];
  assign last_idx = bus.num_vec - 8'd1;
  assign mismatch = (bus.sum_in != exp_sum);
  assign last_vec = (vec_cnt_q == last_idx);

  assign err_cnt_d    = (mismatch && (err_cnt_q != ERR_MAX)) ? err_cnt_q + 8'd1 : err_cnt_q;
  assign first_fail_d = (mismatch && (first_fail_q == NO_FAIL)) ? vec_cnt_q : first_fail_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      vec_cnt_q    <= '0;
      err_cnt_q    <= '0;
      first_fail_q <= NO_FAIL;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            vec_cnt_q    <= '0;
            err_cnt_q    <= '0;
            first_fail_q <= NO_FAIL;
            pass_q       <= 1'b0;
            busy_q       <= 1'b1;
            state_q      <= ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          state_q <= ST_CHECK;
        end
        ST_CHECK: begin
          err_cnt_q    <= err_cnt_d;
          first_fail_q <= first_fail_d;
          if (last_vec) begin
            // Verdict includes the result of this final check.
            pass_q  <= (err_cnt_d == 8'd0);
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            vec_cnt_q <= vec_cnt_q + 8'd1;
            state_q   <= ST_DRIVE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.op_a       = lfsr_val[0];
  assign bus.op_b       = lfsr_val[1];
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_cnt_q;
  assign bus.first_fail = first_fail_q;

endmodule

// File: tb/tb_adder_bist.sv
// Self-checking bench for adder_bist: spec vector table, randomized runs
// against a reference model, and hand sequences for start-ignore and reset.
module tb_adder_bist;

  localparam int M_GOOD  = 0;  // correct adder
  localparam int M_XOR   = 1;  // sum bit0 inverted on every vector
  localparam int M_ONE   = 2;  // wrong only on one chosen operand pair
  localparam int M_WRONG = 3;  // always wrong
  localparam int M_HASH  = 4;  // wrong on a pseudo-random subset of pairs

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   mode = M_GOOD;
  logic [7:0] fa = 8'h00;
  logic [7:0] fb = 8'h00;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [7:0] exp_a [256];
  logic [7:0] exp_b [256];

  adder_bist_if bus ();

  adder_bist #(.SEED_A(8'hA5), .SEED_B(8'h3C)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic bit hash_fault(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] mix;
    mix = a ^ {b[3:0], b[7:4]};
    return (mix % 8'd5) == 8'd0;
  endfunction

  function automatic bit is_wrong(input int md, input logic [7:0] a, input logic [7:0] b);
    case (md)
      M_XOR, M_WRONG: return 1'b1;
      M_ONE:          return (a == fa) && (b == fb);
      M_HASH:         return hash_fault(a, b);
      default:        return 1'b0;
    endcase
  endfunction

  // Behavioural adder under test.
  always_comb begin
    logic [7:0] good;
    good = bus.op_a + bus.op_b;
    bus.sum_in = good;
    case (mode)
      M_XOR:   bus.sum_in = good ^ 8'h01;
      M_WRONG: bus.sum_in = good + 8'd1;
      M_ONE:   if ((bus.op_a == fa) && (bus.op_b == fb)) bus.sum_in = good ^ 8'h80;
      M_HASH:  if (hash_fault(bus.op_a, bus.op_b)) bus.sum_in = good ^ 8'h10;
      default: bus.sum_in = good;
    endcase
  end

  function automatic logic [7:0] step8(input logic [7:0] x);
    return {x[6:0], x[7] ^ x[5] ^ x[4] ^ x[3]};
  endfunction

  task automatic gen_vectors(input int n);
    logic [7:0] a, b;
    a = 8'hA5;
    b = 8'h3C;
    for (int i = 0; i < n; i++) begin
      exp_a[i] = a;
      exp_b[i] = b;
      a = step8(a);
      b = step8(b);
    end
  endtask

  task automatic model_expect(input int n, input int md, output int e_err, output int e_ff, output int e_pass);
    e_err = 0;
    e_ff  = 255;
    for (int i = 0; i < n; i++) begin
      if (is_wrong(md, exp_a[i], exp_b[i])) begin
        if (e_ff == 255) e_ff = i;
        e_err++;
      end
    end
    if (e_err > 255) e_err = 255;
    e_pass = (e_err == 0) ? 1 : 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Launch a run and follow it to done. Cycle 1 is the first cycle after the
  // accepting edge; operands of vector k are visible in cycles 2k+1 and 2k+2.
  task automatic run_bist(input logic [7:0] nv, output int cyc, output int ops_bad,
                          output logic [7:0] a0, output logic [7:0] b0,
                          output logic [7:0] a1, output logic [7:0] b1);
    int n;
    int idx;
    n = (nv == 8'd0) ? 256 : int'(nv);
    ops_bad = 0;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    @(negedge clk);
    bus.start   = 1'b1;
    bus.num_vec = nv;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    while (!bus.done && cyc < 600) begin
      idx = (cyc - 1) / 2;
      if (cyc == 1) begin a0 = bus.op_a; b0 = bus.op_b; end
      if (cyc == 3) begin a1 = bus.op_a; b1 = bus.op_b; end
      if (idx < n) begin
        if (bus.op_a !== exp_a[idx] || bus.op_b !== exp_b[idx] || bus.busy !== 1'b1) ops_bad++;
      end
      @(negedge clk);
      cyc++;
    end
  endtask

  typedef struct {
    logic [7:0] nv;
    int md;
    int fidx;
    int e_err;
    int e_ff;
    int e_pass;
    int e_cyc;
  } vec_t;

  initial begin
    vec_t tbl [4];
    int cyc, ops_bad, e_err, e_ff, e_pass, n, dones, dcyc;
    logic [7:0] a0, b0, a1, b1;

    tbl[0] = '{8'd4, M_GOOD,  0, 0,   255, 1, 9};
    tbl[1] = '{8'd4, M_XOR,   0, 4,   0,   0, 9};
    tbl[2] = '{8'd5, M_ONE,   2, 1,   2,   0, 11};
    tbl[3] = '{8'd0, M_WRONG, 0, 255, 0,   0, 513};

    bus.start   = 1'b0;
    bus.num_vec = 8'd4;

    // Reset state
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_pass", int'(bus.pass), 0);
    chk("rst_op_a", int'(bus.op_a), 0);
    chk("rst_op_b", int'(bus.op_b), 0);
    chk("rst_err",  int'(bus.err_cnt), 0);
    chk("rst_ff",   int'(bus.first_fail), 255);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Spec table
    for (int t = 0; t < 4; t++) begin
      n = (tbl[t].nv == 8'd0) ? 256 : int'(tbl[t].nv);
      gen_vectors(n);
      fa = exp_a[tbl[t].fidx];
      fb = exp_b[tbl[t].fidx];
      mode = tbl[t].md;
      run_bist(tbl[t].nv, cyc, ops_bad, a0, b0, a1, b1);
      $display("table %0d: nv=%0d mode=%0d cycles=%0d err=%0d ff=%0d pass=%0d",
               t, n, tbl[t].md, cyc, bus.err_cnt, bus.first_fail, bus.pass);
      chk("tbl_cycles", cyc, tbl[t].e_cyc);
      chk("tbl_ops", ops_bad, 0);
      chk("tbl_vec0_a", int'(a0), 'hA5);
      chk("tbl_vec0_b", int'(b0), 'h3C);
      chk("tbl_vec1_a", int'(a1), 'h4A);
      chk("tbl_vec1_b", int'(b1), 'h79);
      chk("tbl_err", int'(bus.err_cnt), tbl[t].e_err);
      chk("tbl_ff", int'(bus.first_fail), tbl[t].e_ff);
      chk("tbl_pass", int'(bus.pass), tbl[t].e_pass);
      @(negedge clk);
      chk("tbl_done_width", int'(bus.done), 0);
      chk("tbl_busy_after", int'(bus.busy), 0);
      repeat (2) @(negedge clk);
      chk("tbl_pass_held", int'(bus.pass), tbl[t].e_pass);
    end

    // Randomized runs against the model
    mode = M_HASH;
    for (int r = 0; r < 8; r++) begin
      logic [7:0] nv;
      nv = 8'($urandom_range(1, 40));
      gen_vectors(int'(nv));
      model_expect(int'(nv), M_HASH, e_err, e_ff, e_pass);
      run_bist(nv, cyc, ops_bad, a0, b0, a1, b1);
      $display("random %0d: nv=%0d cycles=%0d err=%0d ff=%0d pass=%0d",
               r, nv, cyc, bus.err_cnt, bus.first_fail, bus.pass);
      chk("rnd_cycles", cyc, 2 * int'(nv) + 1);
      chk("rnd_ops", ops_bad, 0);
      chk("rnd_err", int'(bus.err_cnt), e_err);
      chk("rnd_ff", int'(bus.first_fail), e_ff);
      chk("rnd_pass", int'(bus.pass), e_pass);
      @(negedge clk);
    end

    // Start pulses mid-run are ignored
    mode = M_XOR;
    gen_vectors(4);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.num_vec = 8'd4;
    @(negedge clk);
    dones = 0;
    dcyc  = 0;
    for (int c = 1; c <= 30; c++) begin
      if (bus.done) begin dones++; dcyc = c; end
      bus.start = (c == 3 || c == 8);
      @(negedge clk);
    end
    bus.start = 1'b0;
    $display("ignore-start: dones=%0d at cycle %0d err=%0d busy=%0d", dones, dcyc, bus.err_cnt, bus.busy);
    chk("ign_dones", dones, 1);
    chk("ign_done_cycle", dcyc, 9);
    chk("ign_err", int'(bus.err_cnt), 4);
    chk("ign_busy", int'(bus.busy), 0);

    // Reset in CHECK of vector 1, then rerun from the seeds
    gen_vectors(4);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.num_vec = 8'd4;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_err_before", int'(bus.err_cnt), 1);
    rst = 1'b1;
    #1;
    $display("mid-run reset: busy=%0d op_a=%0d op_b=%0d ff=%0d err=%0d",
             bus.busy, bus.op_a, bus.op_b, bus.first_fail, bus.err_cnt);
    chk("mid_busy", int'(bus.busy), 0);
    chk("mid_op_a", int'(bus.op_a), 0);
    chk("mid_op_b", int'(bus.op_b), 0);
    chk("mid_ff", int'(bus.first_fail), 255);
    chk("mid_err", int'(bus.err_cnt), 0);
    chk("mid_done", int'(bus.done), 0);
    @(negedge clk);
    rst  = 1'b0;
    mode = M_GOOD;
    run_bist(8'd4, cyc, ops_bad, a0, b0, a1, b1);
    $display("rerun after reset: cycles=%0d err=%0d pass=%0d", cyc, bus.err_cnt, bus.pass);
    chk("rerun_cycles", cyc, 9);
    chk("rerun_ops", ops_bad, 0);
    chk("rerun_vec0_a", int'(a0), 'hA5);
    chk("rerun_vec0_b", int'(b0), 'h3C);
    chk("rerun_pass", int'(bus.pass), 1);
    chk("rerun_ff", int'(bus.first_fail), 255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/adder_bist.md
ADDER_BIST -- requirements
Module: adder_bist

Interface
REQ-001 Parameter SEED_A, default 8'hA5, initial LFSR value for operand A; a zero value SHALL be replaced by 8'h01.
REQ-002 Parameter SEED_B, default 8'h3C, initial LFSR value for operand B; a zero value SHALL be replaced by 8'h01.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 start  in  1  run request; sampled only in IDLE.
REQ-006 num_vec  in  8  vector count per run; 0 means 256.
REQ-007 op_a  out  8  registered operand A to the adder under test (its ui_in).
REQ-008 op_b  out  8  registered operand B to the adder under test (its uio_in).
REQ-009 sum_in  in  8  adder result returned from the device under test (its uo_out).
REQ-010 busy  out  1  high in DRIVE and CHECK.
REQ-011 done  out  1  one-cycle pulse in DONE.
REQ-012 pass  out  1  high when the last completed run had err_cnt==0; held until next accepted start.
REQ-013 err_cnt  out  8  mismatch count, saturating at 255.
REQ-014 first_fail  out  8  index of first mismatching vector; 8'hFF when none.

Function
REQ-015 FSM states SHALL be IDLE, DRIVE, CHECK, DONE.
REQ-016 IDLE with start=1 at an edge: load op_a=SEED_A, op_b=SEED_B, vec_cnt=0, err_cnt=0, first_fail=8'hFF, pass=0; go to DRIVE.
REQ-017 IDLE with start=0: stay; op_a/op_b/err_cnt/first_fail/pass hold.
REQ-018 DRIVE: one settle cycle; unconditionally go to CHECK; operands stable.
REQ-019 CHECK: compare sum_in with (op_a+op_b) mod 256, carry discarded; on mismatch increment err_cnt (saturating) and set first_fail=vec_cnt if first_fail==8'hFF.
REQ-020 CHECK with vec_cnt==num_vec-1 (8-bit wrap, so num_vec=0 ends at vec_cnt 255): go to DONE; operands hold.
REQ-021 CHECK otherwise: advance both LFSRs one step, vec_cnt+1, go to DRIVE.
REQ-022 LFSR step: Fibonacci, polynomial x^8+x^6+x^5+x^4+1; next = {cur[6:0], cur[7]^cur[5]^cur[4]^cur[3]}.
REQ-023 DONE: done=1 for exactly one cycle; pass=(err_cnt==0 including the final CHECK); go to IDLE.
REQ-024 start during DRIVE, CHECK or DONE SHALL be ignored, not queued.
REQ-025 Run of N vectors: done asserts 2N+1 cycles after the edge accepting start.
REQ-026 num_vec SHALL be sampled continuously; the team requires it held stable while busy (behaviour otherwise undefined).

Reset
REQ-027 rst=1 SHALL immediately force IDLE, op_a=0, op_b=0, vec_cnt=0, err_cnt=0, first_fail=8'hFF, pass=0, done=0, busy=0, including mid-run.
REQ-028 First start accepted on the first edge after rst deasserts.

Structure
REQ-029 Shared package SHALL hold the FSM state enum, the LFSR tap mask 8'hB8, and the seed-zero substitute constant.
REQ-030 One sub-module lfsr8 (load, step, seed, value); instantiated twice.
REQ-031 Target size 120-400 RTL lines; no memories.

Verification
REQ-032 Correct adder model, num_vec=4 -> vectors (A5,3C),(4A,79),...; done 9 cycles after start; pass=1; err_cnt=0; first_fail=FF.
REQ-033 Model XORs sum bit0 on every vector, num_vec=4 -> err_cnt=4, first_fail=0, pass=0.
REQ-034 Fault only on vector index 2, num_vec=5 -> err_cnt=1, first_fail=2, done 11 cycles after start.
REQ-035 num_vec=0, always-wrong model -> 256 checks, done 513 cycles after start, err_cnt=255 (saturated at 255th), first_fail=0.
REQ-036 start pulsed in cycles 3 and 8 of a running 4-vector run -> single done pulse; no restart; err_cnt unaffected.
REQ-037 rst asserted in CHECK of vector 1 -> same cycle busy=0, op_a=op_b=0, first_fail=FF; new start after release reruns from SEED_A/SEED_B.
